// File: rtl/snake_pkg.sv
// Shared encodings for the snake game-logic stage: directions, cell values,
// grid defaults and the mover state enumeration.
package snake_pkg;

    localparam int GRID_W_DEF  = 80;
    localparam int GRID_H_DEF  = 60;
    localparam int MAX_LEN_DEF = 64;
    localparam int START_X_DEF = 40;
    localparam int START_Y_DEF = 30;

    localparam logic [1:0] DIR_UP    = 2'd0;
    localparam logic [1:0] DIR_RIGHT = 2'd1;
    localparam logic [1:0] DIR_DOWN  = 2'd2;
    localparam logic [1:0] DIR_LEFT  = 2'd3;

    localparam logic [2:0] CELL_EMPTY = 3'b000;
    localparam logic [2:0] CELL_BODY  = 3'b001;

    typedef enum logic [2:0] {
        ST_INIT       = 3'd0,
        ST_IDLE       = 3'd1,
        ST_READ       = 3'd2,
        ST_WAIT_RD    = 3'd3,
        ST_WRITE_HEAD = 3'd4,
        ST_ERASE_TAIL = 3'd5,
        ST_DEAD       = 3'd6
    } state_e;

    function automatic logic [12:0] pack_cell(input logic [6:0] x, input logic [5:0] y);
        return {x, y};
    endfunction

endpackage

// File: rtl/snake_ring.sv
// Circular body buffer: push at the head end, pop at the tail end.
// Entries are packed {x, y} cell coordinates.
module snake_ring
    import snake_pkg::*;
#(
    parameter int          MAX_LEN   = MAX_LEN_DEF,
    parameter logic [12:0] INIT_DATA = 13'd0
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        i_push,
    input  logic        i_pop,
    input  logic [12:0] i_push_data,
    output logic [12:0] o_head_data,
    output logic [12:0] o_tail_data,
    output logic [6:0]  o_count
);
    localparam int               PTR_W    = $clog2(MAX_LEN);
    localparam logic [PTR_W-1:0] LAST_PTR = PTR_W'(MAX_LEN - 1);

    logic [12:0]      r_mem [MAX_LEN];
    logic [PTR_W-1:0] r_wr_ptr;
    logic [PTR_W-1:0] r_rd_ptr;
    logic [6:0]       r_count;
    logic [PTR_W-1:0] w_head_ptr;

    function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
        if (p == LAST_PTR) begin
            return PTR_W'(0);
        end else begin
            return p + PTR_W'(1);
        end
    endfunction

    // Newest entry sits one slot behind the write pointer.
    always_comb begin
        if (r_wr_ptr == PTR_W'(0)) begin
            w_head_ptr = LAST_PTR;
        end else begin
            w_head_ptr = r_wr_ptr - PTR_W'(1);
        end
    end

    // Storage, pointers and occupancy; reset leaves only INIT_DATA in slot 0.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < MAX_LEN; i++) begin
                r_mem[i] <= (i == 0) ? INIT_DATA : 13'd0;
            end
            r_wr_ptr <= PTR_W'(1);
            r_rd_ptr <= PTR_W'(0);
            r_count  <= 7'd1;
        end else begin
            if (i_push) begin
                r_mem[r_wr_ptr] <= i_push_data;
                r_wr_ptr        <= ptr_inc(r_wr_ptr);
            end
            if (i_pop) begin
                r_rd_ptr <= ptr_inc(r_rd_ptr);
            end
            case ({i_push, i_pop})
                2'b10:   r_count <= r_count + 7'd1;
                2'b01:   r_count <= r_count - 7'd1;
                default: r_count <= r_count;
            endcase
        end
    end

    assign o_head_data = r_mem[w_head_ptr];
    assign o_tail_data = r_mem[r_rd_ptr];
    assign o_count     = r_count;

endmodule

// File: rtl/snake_mover.sv
// Snake game-logic stage: on each tick reads the target cell, writes the new
// head and erases the tail through a registered request/grant RAM port.
module snake_mover
    import snake_pkg::*;
#(
    parameter int GRID_W  = GRID_W_DEF,
    parameter int GRID_H  = GRID_H_DEF,
    parameter int MAX_LEN = MAX_LEN_DEF,
    parameter int START_X = START_X_DEF,
    parameter int START_Y = START_Y_DEF
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       tick,
    input  logic [1:0] dir_in,
    input  logic [6:0] food_x,
    input  logic [5:0] food_y,
    output logic       mem_req,
    input  logic       mem_gnt,
    output logic       mem_we,
    output logic [6:0] mem_x,
    output logic [5:0] mem_y,
    output logic [2:0] mem_wdata,
    input  logic [2:0] mem_rdata,
    output logic [6:0] head_x,
    output logic [5:0] head_y,
    output logic [6:0] length,
    output logic       ate,
    output logic       dead,
    output logic       busy
);
    state_e     r_state;
    state_e     w_state_nx;
    logic [1:0] r_dir;
    logic [1:0] w_dir_nx;
    logic [6:0] r_next_x;
    logic [5:0] r_next_y;
    logic [6:0] w_next_x_nx;
    logic [5:0] w_next_y_nx;
    logic       r_mem_req;
    logic       r_mem_we;
    logic [6:0] r_mem_x;
    logic [5:0] r_mem_y;
    logic [2:0] r_mem_wdata;
    logic       w_req_nx;
    logic       w_we_nx;
    logic [6:0] w_x_nx;
    logic [5:0] w_y_nx;
    logic [2:0] w_wdata_nx;
    logic       r_ate;
    logic       w_ate_nx;
    logic       r_dead;
    logic       r_busy;

    logic       w_grant;
    logic [1:0] w_dir_sel;
    logic [7:0] w_cand_x;
    logic [6:0] w_cand_y;
    logic       w_out_of_grid;
    logic       w_food_hit;
    logic       w_full;
    logic       w_push;
    logic       w_pop;
    logic [12:0] w_ring_head;
    logic [12:0] w_ring_tail;
    logic [6:0]  w_len;

    snake_ring #(
        .MAX_LEN   (MAX_LEN),
        .INIT_DATA (pack_cell(7'(START_X), 6'(START_Y)))
    ) u_ring (
        .clk         (clk),
        .reset       (reset),
        .i_push      (w_push),
        .i_pop       (w_pop),
        .i_push_data (pack_cell(r_next_x, r_next_y)),
        .o_head_data (w_ring_head),
        .o_tail_data (w_ring_tail),
        .o_count     (w_len)
    );

    assign w_grant    = r_mem_req && mem_gnt;
    assign w_food_hit = (r_next_x == food_x) && (r_next_y == food_y);
    assign w_full     = (w_len == 7'(MAX_LEN));
    assign w_dir_sel  = (dir_in == (r_dir ^ 2'b10)) ? r_dir : dir_in;

    // Candidate head one cell along the chosen axis; the extra MSB turns
    // a step off the low edge into a large value caught by the range test.
    always_comb begin
        w_cand_x = {1'b0, w_ring_head[12:6]};
        w_cand_y = {1'b0, w_ring_head[5:0]};
        case (w_dir_sel)
            DIR_UP:    w_cand_y = w_cand_y - 7'd1;
            DIR_RIGHT: w_cand_x = w_cand_x + 8'd1;
            DIR_DOWN:  w_cand_y = w_cand_y + 7'd1;
            DIR_LEFT:  w_cand_x = w_cand_x - 8'd1;
            default:   w_cand_x = w_cand_x;
        endcase
        w_out_of_grid = (w_cand_x >= 8'(GRID_W)) || (w_cand_y >= 7'(GRID_H));
    end

    // Next-state and next RAM-port values; the port holds until granted.
    always_comb begin
        w_state_nx  = r_state;
        w_dir_nx    = r_dir;
        w_next_x_nx = r_next_x;
        w_next_y_nx = r_next_y;
        w_req_nx    = w_grant ? 1'b0 : r_mem_req;
        w_we_nx     = r_mem_we;
        w_x_nx      = r_mem_x;
        w_y_nx      = r_mem_y;
        w_wdata_nx  = r_mem_wdata;
        w_ate_nx    = 1'b0;
        w_push      = 1'b0;
        w_pop       = 1'b0;
        case (r_state)
            ST_INIT: begin
                if (!r_mem_req) begin
                    w_req_nx   = 1'b1;
                    w_we_nx    = 1'b1;
                    w_x_nx     = 7'(START_X);
                    w_y_nx     = 6'(START_Y);
                    w_wdata_nx = CELL_BODY;
                end else if (w_grant) begin
                    w_state_nx = ST_IDLE;
                end else begin
                    w_state_nx = ST_INIT;
                end
            end
            ST_IDLE: begin
                if (tick) begin
                    w_dir_nx = w_dir_sel;
                    if (w_out_of_grid) begin
                        w_state_nx = ST_DEAD;
                    end else begin
                        w_state_nx  = ST_READ;
                        w_next_x_nx = w_cand_x[6:0];
                        w_next_y_nx = w_cand_y[5:0];
                        w_req_nx    = 1'b1;
                        w_we_nx     = 1'b0;
                        w_x_nx      = w_cand_x[6:0];
                        w_y_nx      = w_cand_y[5:0];
                        w_wdata_nx  = CELL_EMPTY;
                    end
                end else begin
                    w_state_nx = ST_IDLE;
                end
            end
            ST_READ: begin
                if (w_grant) begin
                    w_state_nx = ST_WAIT_RD;
                end else begin
                    w_state_nx = ST_READ;
                end
            end
            ST_WAIT_RD: begin
                if (mem_rdata != CELL_EMPTY) begin
                    w_state_nx = ST_DEAD;
                end else begin
                    w_state_nx = ST_WRITE_HEAD;
                    w_req_nx   = 1'b1;
                    w_we_nx    = 1'b1;
                    w_x_nx     = r_next_x;
                    w_y_nx     = r_next_y;
                    w_wdata_nx = CELL_BODY;
                end
            end
            ST_WRITE_HEAD: begin
                if (w_grant) begin
                    w_push   = 1'b1;
                    w_ate_nx = w_food_hit;
                    if (w_food_hit && !w_full) begin
                        w_state_nx = ST_IDLE;
                    end else begin
                        // Tail leaves the ring now; its address rides in the erase request.
                        w_pop      = 1'b1;
                        w_state_nx = ST_ERASE_TAIL;
                        w_req_nx   = 1'b1;
                        w_we_nx    = 1'b1;
                        w_x_nx     = w_ring_tail[12:6];
                        w_y_nx     = w_ring_tail[5:0];
                        w_wdata_nx = CELL_EMPTY;
                    end
                end else begin
                    w_state_nx = ST_WRITE_HEAD;
                end
            end
            ST_ERASE_TAIL: begin
                if (w_grant) begin
                    w_state_nx = ST_IDLE;
                end else begin
                    w_state_nx = ST_ERASE_TAIL;
                end
            end
            ST_DEAD: begin
                w_state_nx = ST_DEAD;
                w_req_nx   = 1'b0;
            end
            default: begin
                w_state_nx = ST_DEAD;
                w_req_nx   = 1'b0;
            end
        endcase
    end

    // State, direction, RAM port and status registers.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state     <= ST_INIT;
            r_dir       <= DIR_RIGHT;
            r_next_x    <= 7'd0;
            r_next_y    <= 6'd0;
            r_mem_req   <= 1'b0;
            r_mem_we    <= 1'b0;
            r_mem_x     <= 7'd0;
            r_mem_y     <= 6'd0;
            r_mem_wdata <= 3'd0;
            r_ate       <= 1'b0;
            r_dead      <= 1'b0;
            r_busy      <= 1'b1;
        end else begin
            r_state     <= w_state_nx;
            r_dir       <= w_dir_nx;
            r_next_x    <= w_next_x_nx;
            r_next_y    <= w_next_y_nx;
            r_mem_req   <= w_req_nx;
            r_mem_we    <= w_we_nx;
            r_mem_x     <= w_x_nx;
            r_mem_y     <= w_y_nx;
            r_mem_wdata <= w_wdata_nx;
            r_ate       <= w_ate_nx;
            r_dead      <= (w_state_nx == ST_DEAD);
            r_busy      <= (w_state_nx != ST_IDLE) && (w_state_nx != ST_DEAD);
        end
    end

    assign mem_req   = r_mem_req;
    assign mem_we    = r_mem_we;
    assign mem_x     = r_mem_x;
    assign mem_y     = r_mem_y;
    assign mem_wdata = r_mem_wdata;
    assign head_x    = w_ring_head[12:6];
    assign head_y    = w_ring_head[5:0];
    assign length    = w_len;
    assign ate       = r_ate;
    assign dead      = r_dead;
    assign busy      = r_busy;

endmodule

// File: tb/tb_snake_mover.sv
// Bench for snake_mover: a body-queue model of the snake plus a play-area RAM
// model; every granted access and the idle-time status are compared each cycle.
module tb_snake_mover;
    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic       tick = 1'b0;
    logic [1:0] dir_in = 2'd1;
    logic [6:0] food_x = 7'd0;
    logic [5:0] food_y = 6'd0;
    logic       mem_req;
    logic       mem_gnt = 1'b1;
    logic       mem_we;
    logic [6:0] mem_x;
    logic [5:0] mem_y;
    logic [2:0] mem_wdata;
    logic [2:0] mem_rdata = 3'd0;
    logic [6:0] head_x;
    logic [5:0] head_y;
    logic [6:0] length;
    logic       ate;
    logic       dead;
    logic       busy;

    int checks = 0;
    int errors = 0;

    logic [2:0]  ram [0:79][0:59];
    logic [16:0] exp_q[$];
    int body_x[$];
    int body_y[$];
    int m_dir;
    int m_dead;
    int m_ate;
    int ate_cnt;
    int req_cycles;

    snake_mover dut (
        .clk(clk), .reset(reset), .tick(tick), .dir_in(dir_in),
        .food_x(food_x), .food_y(food_y),
        .mem_req(mem_req), .mem_gnt(mem_gnt), .mem_we(mem_we),
        .mem_x(mem_x), .mem_y(mem_y), .mem_wdata(mem_wdata), .mem_rdata(mem_rdata),
        .head_x(head_x), .head_y(head_y), .length(length),
        .ate(ate), .dead(dead), .busy(busy)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    function automatic logic [16:0] acc(input int we, input int x, input int y, input int wd);
        return {1'(we), 7'(x), 6'(y), 3'(wd)};
    endfunction

    // Play-area RAM: writes land on grant, read data appears the following cycle.
    always @(posedge clk) begin
        mem_rdata <= 3'd0;
        if (!reset && mem_req && mem_gnt && mem_x < 7'd80 && mem_y < 6'd60) begin
            if (mem_we) ram[mem_x][mem_y] <= mem_wdata;
            else        mem_rdata <= ram[mem_x][mem_y];
        end
    end

    // Compare process: every granted access, and status whenever the block rests.
    always @(negedge clk) begin
        if (!reset) begin
            if (mem_req) req_cycles++;
            if (ate) ate_cnt++;
            if (mem_req && mem_gnt) begin
                if (exp_q.size() == 0) check("unexpected_access", int'({mem_we, mem_x, mem_y, mem_wdata}), -1);
                else check("access", int'({mem_we, mem_x, mem_y, mem_wdata}), int'(exp_q.pop_front()));
            end
            if (!busy && !tick) begin
                check("head_x", int'(head_x), body_x[$]);
                check("head_y", int'(head_y), body_y[$]);
                check("length", int'(length), body_x.size());
                check("dead", int'(dead), m_dead);
            end
        end
    end

    task automatic model_reset();
        body_x.delete(); body_y.delete();
        body_x.push_back(40); body_y.push_back(30);
        m_dir = 1; m_dead = 0; m_ate = 0; ate_cnt = 0;
        exp_q.delete();
        exp_q.push_back(acc(1, 40, 30, 1));
        for (int x = 0; x < 80; x++)
            for (int y = 0; y < 60; y++) ram[x][y] = 3'd0;
    endtask

    // One game step from the rules: turn, bounds, collision, grow or slide.
    task automatic model_step(input int d);
        int nx, ny;
        if (d != (m_dir + 2) % 4) m_dir = d;
        nx = body_x[$] + ((m_dir == 1) ? 1 : 0) - ((m_dir == 3) ? 1 : 0);
        ny = body_y[$] + ((m_dir == 2) ? 1 : 0) - ((m_dir == 0) ? 1 : 0);
        if (nx < 0 || nx >= 80 || ny < 0 || ny >= 60) begin
            m_dead = 1;
            return;
        end
        exp_q.push_back(acc(0, nx, ny, 0));
        if (ram[nx][ny] != 3'd0) begin
            m_dead = 1;
            return;
        end
        exp_q.push_back(acc(1, nx, ny, 1));
        body_x.push_back(nx); body_y.push_back(ny);
        if (nx == int'(food_x) && ny == int'(food_y)) m_ate++;
        if (!(nx == int'(food_x) && ny == int'(food_y)) || body_x.size() > 64) begin
            exp_q.push_back(acc(1, body_x[0], body_y[0], 0));
            void'(body_x.pop_front()); void'(body_y.pop_front());
        end
    endtask

    task automatic do_step(input logic [1:0] d, output int cyc);
        model_step(int'(d));
        dir_in = d; tick = 1'b1; cyc = 0;
        do begin
            @(posedge clk); #1;
            tick = 1'b0; cyc++;
        end while (busy && cyc < 100);
        check("step_done", int'(busy), 0);
        @(negedge clk); #1;
        check("acc_drained", exp_q.size(), 0);
        check("ate_count", ate_cnt, m_ate);
        @(posedge clk); #1;
    endtask

    task automatic do_reset();
        reset = 1'b1; mem_gnt = 1'b1; tick = 1'b0;
        model_reset();
        repeat (2) @(posedge clk);
        #1 reset = 1'b0;
        for (int i = 0; i < 20 && busy; i++) begin @(posedge clk); #1; end
        check("init_done", int'(busy), 0);
        check("init_drained", exp_q.size(), 0);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int cyc, rc;
        model_reset();
        repeat (2) @(posedge clk);
        #1;
        check("rst_req", int'(mem_req), 0);
        check("rst_busy", int'(busy), 1);
        check("rst_dead", int'(dead), 0);
        check("rst_ate", int'(ate), 0);
        check("rst_len", int'(length), 1);
        check("rst_hx", int'(head_x), 40);
        check("rst_hy", int'(head_y), 30);
        reset = 1'b0;
        for (int i = 0; i < 20 && busy; i++) begin @(posedge clk); #1; end
        check("init_done", int'(busy), 0);
        check("init_drained", exp_q.size(), 0);

        // plain step right; tail at (40,30) erased
        food_x = 7'd0; food_y = 6'd0;
        do_step(2'd1, cyc);
        check("latency", cyc, 5);
        check("step1_hx", int'(head_x), 41);
        check("step1_erased", int'(ram[40][30]), 0);
        // eat at (42,30): grows, no erase
        food_x = 7'd42; food_y = 6'd30;
        do_step(2'd1, cyc);
        check("eat_len", int'(length), 2);
        check("eat_pulses", ate_cnt, 1);
        check("eat_kept_tail", int'(ram[41][30]), 1);
        food_x = 7'd0; food_y = 6'd0;
        do_step(2'd1, cyc);
        check("after_eat_erase", int'(ram[41][30]), 0);
        // reverse requests are ignored
        do_step(2'd3, cyc);
        check("rev_hx", int'(head_x), 44);
        do_step(2'd0, cyc);
        do_step(2'd2, cyc);
        check("rev_hy", int'(head_y), 28);

        // grant stall during READ, with a dropped tick
        mem_gnt = 1'b0;
        model_step(0);
        dir_in = 2'd0; tick = 1'b1;
        @(posedge clk); #1;
        tick = 1'b0;
        for (int i = 0; i < 10; i++) begin
            tick = (i == 4); dir_in = 2'd1;
            @(posedge clk); #1;
            check("stall_req", int'(mem_req), 1);
            check("stall_we", int'(mem_we), 0);
            check("stall_x", int'(mem_x), 44);
            check("stall_y", int'(mem_y), 27);
        end
        tick = 1'b0; mem_gnt = 1'b1;
        for (int i = 0; i < 20 && busy; i++) begin @(posedge clk); #1; end
        @(negedge clk); #1;
        check("stall_drained", exp_q.size(), 0);
        check("stall_hy", int'(head_y), 27);
        @(posedge clk); #1;

        // body already in the target cell: death after the read, no write
        ram[44][26] = 3'b001;
        do_step(2'd0, cyc);
        check("hit_dead", int'(dead), 1);
        rc = req_cycles;
        dir_in = 2'd0; tick = 1'b1;
        @(posedge clk); #1; tick = 1'b0;
        repeat (8) @(posedge clk);
        #1;
        check("dead_no_req", req_cycles, rc);
        check("dead_sticky", int'(dead), 1);
        check("dead_busy", int'(busy), 0);

        // reset in the middle of a stalled access drops mem_req at once
        reset = 1'b1; model_reset(); mem_gnt = 1'b0;
        @(posedge clk); #1 reset = 1'b0;
        repeat (3) @(posedge clk);
        #1 check("init_pending", int'(mem_req), 1);
        #2 reset = 1'b1;
        #1 check("async_req_drop", int'(mem_req), 0);
        do_reset();

        // run to the right edge, then off it
        for (int i = 0; i < 39; i++) do_step(2'd1, cyc);
        check("edge_hx", int'(head_x), 79);
        rc = req_cycles;
        do_step(2'd1, cyc);
        check("oob_latency", cyc, 1);
        check("oob_dead", int'(dead), 1);
        check("oob_no_req", req_cycles, rc);
        dir_in = 2'd2; tick = 1'b1;
        @(posedge clk); #1; tick = 1'b0;
        repeat (6) @(posedge clk);
        #1 check("oob_after_tick", req_cycles, rc);
        check("oob_hx", int'(head_x), 79);

        // grow to full length, ring wraps, then eat while full
        do_reset();
        for (int i = 0; i < 39; i++) begin
            food_x = 7'(41 + i); food_y = 6'd30;
            do_step(2'd1, cyc);
        end
        for (int i = 0; i < 24; i++) begin
            food_x = 7'd79; food_y = 6'(31 + i);
            do_step(2'd2, cyc);
        end
        check("full_len", int'(length), 64);
        check("full_ate", ate_cnt, 63);
        food_x = 7'd79; food_y = 6'd55;
        do_step(2'd2, cyc);
        check("full_eat_len", int'(length), 64);
        check("full_eat_tail", int'(ram[40][30]), 0);
        food_x = 7'd0; food_y = 6'd0;
        do_step(2'd2, cyc);
        check("wrap_tail", int'(ram[41][30]), 0);
        check("wrap_hy", int'(head_y), 56);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
